// File: rtl/apb3_cam_pkg.sv
// rtl/apb3_cam_pkg.sv - bus states, register offsets and default ID for the camera register bank
package apb3_cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } bus_state_e;

  // Word offsets above the last CTRL word
  localparam int PULSE_OFS    = 0;
  localparam int IRQ_STAT_OFS = 1;
  localparam int IRQ_EN_OFS   = 2;
  localparam int ID_OFS       = 3;
  localparam int STAT_OFS     = 4;

  localparam logic [31:0] DEFAULT_ID = 32'hABCD_5678;

endpackage

// File: rtl/apb3_irq_ctrl.sv
// rtl/apb3_irq_ctrl.sv - rising-edge capture, sticky W1C status, enable mask and registered irq
module apb3_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  input  logic               en_we_i,
  input  logic [NUM_IRQ-1:0] en_wdata_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] en_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] status_q;
  logic [NUM_IRQ-1:0] status_d;
  logic [NUM_IRQ-1:0] en_q;
  logic               irq_q;

  // A new edge overrides a clear landing on the same bit
  always_comb begin
    status_d = (status_q & ~clr_i) | (irq_src_i & ~prev_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q   <= '0;
      status_q <= '0;
      en_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= irq_src_i;
      status_q <= status_d;
      if (en_we_i) en_q <= en_wdata_i;
      irq_q    <= |(status_q & en_q);
    end
  end

  assign status_o = status_q;
  assign en_o     = en_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/apb3_cam_regbank.sv
// rtl/apb3_cam_regbank.sv - APB3 register slave: control words, pulse trigger, IRQ block, ID, coherent status
module apb3_cam_regbank
  import apb3_cam_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_CTRL    = 8,
  parameter int                    NUM_STAT    = 8,
  parameter int                    NUM_IRQ     = 4,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEFAULT_ID)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERROR,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
  output logic [DATA_WIDTH-1:0]          ctrl_pulse,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in,
  input  logic [NUM_IRQ-1:0]             irq_src,
  output logic                           irq
);

  localparam int WW  = ADDR_WIDTH - 2;
  localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int CIW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int SIW = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

  if (NUM_IRQ > DATA_WIDTH) begin : g_chk_irq
    $error("NUM_IRQ exceeds DATA_WIDTH");
  end
  if (NUM_CTRL + STAT_OFS + NUM_STAT > 2 ** WW) begin : g_chk_map
    $error("register map does not fit the address space");
  end

  bus_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q, pulse_q;
  logic [DATA_WIDTH-1:0] ctrl_q   [NUM_CTRL];
  logic [DATA_WIDTH-1:0] shadow_q [NUM_STAT];
  logic [DATA_WIDTH-1:0] stat_arr [NUM_STAT];

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [WW-1:0]         acc_word;
  int                    wi;
  logic                  is_ctrl, is_pulse, is_irqs, is_irqe, is_id, is_stat, err;
  logic                  go_resp, wr_ok, snap;
  logic [CIW-1:0]        ctrl_idx;
  logic [SIW-1:0]        stat_idx;
  logic [DATA_WIDTH-1:0] rdata_d, pulse_d;
  logic [NUM_IRQ-1:0]    irq_clr, irq_status, irq_en;

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
    assign ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
  end
  for (genvar k = 0; k < NUM_STAT; k++) begin : g_stat_in
    assign stat_arr[k] = stat_in[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // With no wait states the commit happens straight out of ACCESS, so decode the live bus
  always_comb begin
    acc_addr  = (state_q == ST_ACCESS) ? PADDR  : addr_q;
    acc_write = (state_q == ST_ACCESS) ? PWRITE : write_q;
    acc_wdata = (state_q == ST_ACCESS) ? PWDATA : wdata_q;
    go_resp   = ((state_q == ST_ACCESS) && PSEL && PENABLE && (WAIT_CYCLES == 0)) ||
                ((state_q == ST_WAIT) && PSEL && (cnt_q == CW'(1)));

    acc_word = acc_addr[ADDR_WIDTH-1:2];
    wi       = int'(acc_word);
    is_ctrl  = wi < NUM_CTRL;
    is_pulse = wi == NUM_CTRL + PULSE_OFS;
    is_irqs  = wi == NUM_CTRL + IRQ_STAT_OFS;
    is_irqe  = wi == NUM_CTRL + IRQ_EN_OFS;
    is_id    = wi == NUM_CTRL + ID_OFS;
    is_stat  = (wi >= NUM_CTRL + STAT_OFS) && (wi < NUM_CTRL + STAT_OFS + NUM_STAT);
    err      = (acc_addr[1:0] != 2'b00) ||
               !(is_ctrl || is_pulse || is_irqs || is_irqe || is_id || is_stat) ||
               (acc_write && (is_id || is_stat));
    ctrl_idx = acc_word[CIW-1:0];
    stat_idx = SIW'(wi - (NUM_CTRL + STAT_OFS));

    rdata_d = '0;
    if (is_ctrl)      rdata_d = ctrl_q[ctrl_idx];
    else if (is_irqs) rdata_d = DATA_WIDTH'(irq_status);
    else if (is_irqe) rdata_d = DATA_WIDTH'(irq_en);
    else if (is_id)   rdata_d = ID_VALUE;
    else if (is_stat) rdata_d = (stat_idx == '0) ? stat_arr[0] : shadow_q[stat_idx];
    if (err || acc_write) rdata_d = '0;

    wr_ok   = go_resp && acc_write && !err;
    snap    = go_resp && !acc_write && !err && is_stat && (stat_idx == '0);
    irq_clr = (wr_ok && is_irqs) ? acc_wdata[NUM_IRQ-1:0] : '0;
    pulse_d = (wr_ok && is_pulse) ? acc_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      pulse_q   <= '0;
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= '0;
      for (int k = 0; k < NUM_STAT; k++) shadow_q[k] <= '0;
    end else begin
      pready_q  <= go_resp;
      pslverr_q <= go_resp && err;
      pulse_q   <= pulse_d;
      if (go_resp) prdata_q <= rdata_d;
      if (wr_ok && is_ctrl) ctrl_q[ctrl_idx] <= acc_wdata;
      if (snap) for (int k = 0; k < NUM_STAT; k++) shadow_q[k] <= stat_arr[k];
      case (state_q)
        ST_IDLE:   if (PSEL && !PENABLE) state_q <= ST_ACCESS;
        ST_ACCESS: begin
          if (!PSEL) state_q <= ST_IDLE;
          else if (PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt_q   <= CW'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!PSEL) state_q <= ST_IDLE;
          else begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= ST_RESP;
          end
        end
        ST_RESP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  apb3_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk_i      (clk),
    .reset_i    (reset),
    .irq_src_i  (irq_src),
    .clr_i      (irq_clr),
    .en_we_i    (wr_ok && is_irqe),
    .en_wdata_i (acc_wdata[NUM_IRQ-1:0]),
    .status_o   (irq_status),
    .en_o       (irq_en),
    .irq_o      (irq)
  );

  assign PREADY     = pready_q;
  assign PSLVERROR  = pslverr_q;
  assign PRDATA     = prdata_q;
  assign ctrl_pulse = pulse_q;

endmodule

// File: doc/apb3_cam_regbank.md
Name: apb3_cam_regbank

Overview:
- Parametrised APB3 register slave for the camera/display pipeline. It supersedes the fixed 10-register camera control slave.
- Provides:
  - NUM_CTRL read/write control words
  - a write-to-pulse trigger register
  - a sticky, maskable interrupt block with write-1-to-clear (W1C)
  - an ID word
  - NUM_STAT read-only status words, snapshotted coherently
  - configurable wait states and PSLVERROR on bad addresses
- Sits between the SoC APB3 bridge and the camera DMA, RGB, and FPS/debug logic.

Parameters:
- ADDR_WIDTH, 12, APB address width.
- DATA_WIDTH, 32, APB data width.
- NUM_CTRL, 8, number of RW control words.
- NUM_STAT, 8, number of RO status words (at least 1).
- NUM_IRQ, 4, interrupt sources (at most DATA_WIDTH).
- WAIT_CYCLES, 0, extra wait states added beyond the mandatory one.
- ID_VALUE, 32'hABCD_5678, constant returned by the ID register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- PADDR  in  ADDR_WIDTH  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERROR  out  1  error response, valid with PREADY.
- ctrl_regs  out  NUM_CTRL*DATA_WIDTH  control words, flattened; word k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- ctrl_pulse  out  DATA_WIDTH  one-cycle trigger pulses.
- stat_in  in  NUM_STAT*DATA_WIDTH  live status words, flattened in the same layout.
- irq_src  in  NUM_IRQ  level interrupt sources; rising edges are captured.
- irq  out  1  registered interrupt request.

Behaviour:
- Word index is W = PADDR[ADDR_WIDTH-1:2].
- Address map:
  - W 0..NUM_CTRL-1: CTRL, RW.
  - W NUM_CTRL: PULSE, write-only, reads return 0.
  - W NUM_CTRL+1: IRQ_STAT, RO sticky, W1C.
  - W NUM_CTRL+2: IRQ_EN, RW, low NUM_IRQ bits used, upper bits read 0.
  - W NUM_CTRL+3: ID, RO.
  - W NUM_CTRL+4 .. NUM_CTRL+3+NUM_STAT: STAT, RO.
- Error response: any other W, or PADDR[1:0] != 0.
  - PSLVERROR=1 together with PREADY.
  - No register changes; PRDATA=0.
  - A write to an RO word also gives an error and is ignored.
- Bus state machine states: IDLE, ACCESS, WAIT, RESP.
  - IDLE -> ACCESS on PSEL & !PENABLE (setup cycle).
  - In ACCESS, if PSEL & PENABLE: capture PADDR, PWRITE, PWDATA and load the wait counter with WAIT_CYCLES. Go to RESP if WAIT_CYCLES=0, else WAIT.
  - WAIT decrements the counter and goes to RESP when it reaches 0.
  - RESP drives PREADY=1 for exactly one cycle, then goes to IDLE.
  - If PSEL drops in ACCESS or WAIT: go to IDLE, no commit, no PREADY.
- Latency: if the first access cycle is T1, PREADY is high in cycle T1+1+WAIT_CYCLES.
- Write commit occurs on the edge entering RESP. The new value is visible on ctrl_regs during the PREADY cycle.
- PRDATA and PSLVERROR are registered on the same edge. PRDATA holds its value outside RESP. PSLVERROR is 0 outside RESP.
- PULSE: a write drives ctrl_pulse=PWDATA during the RESP cycle only; otherwise ctrl_pulse=0.
- IRQ logic:
  - Edge detect: irq_src is registered; a rising edge (cur & ~prev) sets irq_status[i].
  - A W1C write clears the bits where PWDATA=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - irq is registered: irq = |(irq_status & irq_en), one cycle after the status or enable change.
- STAT snapshot:
  - Reading W=NUM_CTRL+4 (STAT0) latches all of stat_in into a shadow register.
  - The read returns the live stat_in word 0.
  - Reads of STATk, k>0, return shadow word k, so multi-word FIFO counts are coherent.
  - The shadow is 0 until the first STAT0 read.
- Reset, synchronous, in any state:
  - State returns to IDLE; any transfer in flight is dropped without PREADY.
  - CTRL, IRQ_EN, irq_status, the edge-detect register and the shadow are all cleared to 0.
  - PREADY, PSLVERROR, PRDATA, ctrl_pulse and irq are 0.
- Elaboration asserts: NUM_IRQ <= DATA_WIDTH, and NUM_CTRL+4+NUM_STAT <= 2**(ADDR_WIDTH-2).

Decomposition:
- Package apb3_cam_pkg:
  - bus state encoding;
  - relative offsets PULSE_OFS=0, IRQ_STAT_OFS=1, IRQ_EN_OFS=2, ID_OFS=3, STAT_OFS=4, each added to NUM_CTRL;
  - default ID constant.
- Sub-module apb3_irq_ctrl, parametrised by NUM_IRQ: edge detect, sticky status, W1C with set priority, enable mask, registered irq.

Test Plan:
- Reset, then read ID with WAIT_CYCLES=0 -> PREADY high exactly 2 cycles after setup, PRDATA=32'hABCD_5678, PSLVERROR=0.
- Write 32'h0000_00FF to CTRL3, then read it back; rerun with WAIT_CYCLES=3 -> ctrl_regs word 3 = 32'hFF in the PREADY cycle; PREADY lands 3 cycles later than with WAIT_CYCLES=0.
- Write 32'h5 to PULSE -> ctrl_pulse=32'h5 for one cycle, then 0; a subsequent PULSE read returns 0.
- Set IRQ_EN=4'b0010, pulse irq_src[1], then W1C 32'h2 issued in the same cycle as a new rising edge on bit 1 -> irq=1 one cycle after the first status set; bit 1 remains set after the W1C; irq stays 1.
- Access PADDR=12'h0FFC, then PADDR=12'h002 -> PSLVERROR=1 with PREADY, PRDATA=0, no CTRL change.
- Read STAT0 with stat_in word 1 = 10; change word 1 to 20; read STAT1 -> STAT1 returns 10. Assert reset mid-WAIT -> no PREADY, all outputs 0 next cycle.
